// File: rtl/mlcla_mp_seq_if.sv
// Request/result bundle between the ALU control path and the multi-precision sequencer.
// The requester drives the operands and start; the sequencer returns the status and the result.
interface mlcla_mp_seq_if #(
   parameter int NBYTES = 4
);
   localparam int W = 8 * NBYTES;

   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;

   modport master (
      output start, op_sub, a, b, cin,
      input  busy, done, result, cout, ovf, zero
   );

   modport slave (
      input  start, op_sub, a, b, cin,
      output busy, done, result, cout, ovf, zero
   );
endinterface

// File: rtl/mlcla_mp_seq.sv
// Multi-precision add/subtract sequencer. It streams NBYTES-wide operands through one
// 8-bit two-level carry-lookahead adder, least-significant byte first.
module mlcla (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       c0,
   output logic [7:0] z,
   output logic       c8
);
   logic [7:0] g;
   logic [7:0] p;
   logic [7:0] c_bit;
   logic [1:0] gg;
   logic [1:0] gp;
   logic [1:0] cg;

   // The group carry-ins come only from g/p/c0, so the nibble carries never feed each other.
   assign cg[0] = c0;
   assign cg[1] = gg[0] | (gp[0] & c0);
   assign c8    = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign g[gi] = x[gi] & y[gi];
         assign p[gi] = x[gi] ^ y[gi];
         assign z[gi] = p[gi] ^ c_bit[gi];
      end

      for (genvar gi = 0; gi < 2; gi++) begin : g_group
         localparam int L = 4 * gi;
         assign gp[gi] = &p[L +: 4];
         assign gg[gi] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                       | (p[L+3] & p[L+2] & p[L+1] & g[L]);
         assign c_bit[L]   = cg[gi];
         assign c_bit[L+1] = g[L] | (p[L] & cg[gi]);
         assign c_bit[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & cg[gi]);
         assign c_bit[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                           | (p[L+2] & p[L+1] & p[L] & cg[gi]);
      end
   endgenerate
endmodule

module mlcla_mp_seq #(
   parameter int NBYTES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   mlcla_mp_seq_if.slave bus
);
   localparam int W  = 8 * NBYTES;
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [KW-1:0]   k_reg;
   logic            carry_reg;
   logic            sub_reg;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    work_reg;
   logic [W-1:0]    result_reg;
   logic            cout_reg;
   logic            ovf_reg;
   logic            zero_reg;

   logic [7:0]      a_byte [NBYTES];
   logic [7:0]      b_byte [NBYTES];
   logic [W-1:0]    full_word;
   logic [7:0]      z;
   logic            c8;
   logic            last;
   logic            busy;
   logic            done;

   // full_word is the working value with the byte of this edge already merged in.
   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
         assign a_byte[gi] = a_reg[8*gi +: 8];
         assign b_byte[gi] = b_reg[8*gi +: 8];
         assign full_word[8*gi +: 8] = (k_reg == KW'(gi)) ? z : work_reg[8*gi +: 8];
      end
   endgenerate

   mlcla u_adder (
      .x  (a_byte[k_reg]),
      .y  (b_byte[k_reg]),
      .c0 (carry_reg),
      .z  (z),
      .c8 (c8)
   );

   assign last = (k_reg == KW'(NBYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Subtraction is A + ~B + ~borrow; the borrow-out is the inverted final carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_reg      <= '0;
         carry_reg  <= 1'b0;
         sub_reg    <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         work_reg   <= '0;
         result_reg <= '0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         zero_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.op_sub ? ~bus.b : bus.b;
                  carry_reg <= bus.op_sub ^ bus.cin;
                  sub_reg   <= bus.op_sub;
                  k_reg     <= '0;
               end
            end
            RUN: begin
               work_reg  <= full_word;
               carry_reg <= c8;
               k_reg     <= k_reg + 1'b1;
               if (last) begin
                  result_reg <= full_word;
                  cout_reg   <= sub_reg ^ c8;
                  ovf_reg    <= (a_reg[W-1] == b_reg[W-1]) && (z[7] != a_reg[W-1]);
                  zero_reg   <= (full_word == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.result = result_reg;
   assign bus.cout   = cout_reg;
   assign bus.ovf    = ovf_reg;
   assign bus.zero   = zero_reg;
endmodule

// File: tb/tb_mlcla_mp_seq.sv
// Bench for mlcla_mp_seq: table vectors, random operations against an arithmetic model,
// and hand-written handshake and mid-operation reset sequences.
module tb_mlcla_mp_seq;
   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] r;
      logic         c;
      logic         o;
      logic         z;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   logic [W-1:0] prev_result = '0;

   mlcla_mp_seq_if #(.NBYTES(NBYTES)) bus ();

   mlcla_mp_seq #(.NBYTES(NBYTES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Plain integer arithmetic: unsigned for result/carry, signed range test for overflow.
   task automatic model(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, output logic [W-1:0] r, output logic c,
                        output logic o, output logic z);
      longint unsigned ua = 64'(av);
      longint unsigned ub = 64'(bv);
      longint unsigned uc = 64'(ci);
      longint sa = longint'($signed(av));
      longint sb = longint'($signed(bv));
      longint sc = longint'(uc);
      longint sr;
      longint smax = (longint'(1) <<< (W - 1)) - 1;
      longint smin = -(longint'(1) <<< (W - 1));
      longint unsigned s;
      if (!op) begin
         s  = ua + ub + uc;
         r  = s[W-1:0];
         c  = s[W];
         sr = sa + sb + sc;
      end else begin
         s  = ua - ub - uc;
         r  = s[W-1:0];
         c  = (ua < ub + uc);
         sr = sa - sb - sc;
      end
      o = (sr > smax) || (sr < smin);
      z = (r == '0);
   endtask

   task automatic run_op(input string tag, input logic op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ci, input logic [W-1:0] er,
                         input logic ec, input logic eo, input logic ez);
      int n = 0;
      bit seen = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_sub = op;
      bus.a      = av;
      bus.b      = bv;
      bus.cin    = ci;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      while (n < 3 * NBYTES + 4 && !seen) begin
         if (bus.done) begin
            seen = 1;
         end else begin
            check({tag, " busy"}, 64'(bus.busy), 64'd1);
            check({tag, " hold"}, 64'(bus.result), 64'(prev_result));
            @(posedge clk);
            #1;
            n++;
         end
      end
      check({tag, " done_seen"}, 64'(seen), 64'd1);
      check({tag, " latency"}, 64'(n), 64'(NBYTES));
      check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
      check({tag, " result"}, 64'(bus.result), 64'(er));
      check({tag, " cout"}, 64'(bus.cout), 64'(ec));
      check({tag, " ovf"}, 64'(bus.ovf), 64'(eo));
      check({tag, " zero"}, 64'(bus.zero), 64'(ez));
      $display("[TB] %s op_sub=%0b a=%h b=%h cin=%0b -> result=%h cout=%0b ovf=%0b zero=%0b",
               tag, op, av, bv, ci, bus.result, bus.cout, bus.ovf, bus.zero);
      prev_result = er;
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
   endtask

   vec_t vecs [10];
   logic [W-1:0] edge_vals [4];

   initial begin
      logic [W-1:0] er;
      logic ec, eo, ez, op, ci;
      logic [W-1:0] av, bv;
      int n;
      int dn;

      vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      edge_vals = '{32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};

      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.op_sub = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      bus.cin    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst done", 64'(bus.done), 64'd0);
      check("rst result", 64'(bus.result), 64'd0);
      check("rst flags", 64'({bus.cout, bus.ovf, bus.zero}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].z);
      end

      for (int i = 0; i < 40; i++) begin
         op = 1'($urandom_range(0, 1));
         ci = 1'($urandom_range(0, 1));
         av = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
         bv = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
         model(op, av, bv, ci, er, ec, eo, ez);
         run_op($sformatf("rnd%0d", i), op, av, bv, ci, er, ec, eo, ez);
      end

      // start held high through RUN and DONE with a changing operand must not re-trigger
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_sub = 1'b0;
      bus.a      = 32'h12345678;
      bus.b      = 32'h11111111;
      bus.cin    = 1'b0;
      @(posedge clk);
      #1;
      bus.a = 32'hFFFFFFFF;
      n  = 0;
      dn = 0;
      while (n < 3 * NBYTES + 4 && dn == 0) begin
         if (bus.done) dn++;
         else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      check("hs latency", 64'(n), 64'(NBYTES));
      check("hs result", 64'(bus.result), 64'h23456789);
      $display("[TB] handshake add 12345678+11111111 held start -> result=%h", bus.result);
      @(posedge clk);
      #1;
      check("hs idle_busy", 64'(bus.busy), 64'd0);
      check("hs idle_done", 64'(bus.done), 64'd0);
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) dn++;
      end
      check("hs single_done", 64'(dn), 64'd1);
      prev_result = 32'h23456789;

      run_op("preflag", 1'b0, 32'h80000000, 32'h80000001, 1'b0, 32'h00000001, 1'b1, 1'b1, 1'b0);

      // reset asserted mid-cycle after two RUN edges (k == 2)
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op_sub = 1'b0;
      bus.a      = 32'h00000005;
      bus.b      = 32'h00000006;
      bus.cin    = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst busy", 64'(bus.busy), 64'd0);
      check("mrst done", 64'(bus.done), 64'd0);
      check("mrst result", 64'(bus.result), 64'd0);
      check("mrst flags", 64'({bus.cout, bus.ovf, bus.zero}), 64'd0);
      dn = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) dn++;
      end
      check("mrst no_done", 64'(dn), 64'd0);
      $display("[TB] reset mid-operation -> result=%h busy=%0b", bus.result, bus.busy);
      @(negedge clk);
      rst_n = 1'b1;
      prev_result = '0;
      run_op("post_rst", 1'b0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
